// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory_access pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

  localparam int BE_WIDTH = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // funct3[1:0] gives the access size: 00 byte, 01 halfword, anything else word.
  function automatic logic [1:0] align_lo(input logic [1:0] a, input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] a, input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// Selects the addressed byte/halfword of a load word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  // lane select, then extension chosen by size and the unsigned bit
  always_comb begin
    case (a)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = a[1] ? rdata[31:16] : rdata[15:0];
    sext   = ~funct3[2];
    case (funct3[1:0])
      2'b00:   ext_data = {{24{sext & byte_v[7]}}, byte_v};
      2'b01:   ext_data = {{16{sext & half_v[15]}}, half_v};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: performs load/store over a req/gnt/rvalid port, fills MEM/WB.
// Latency: non-mem op 1 cycle; store 2 + gnt wait; load 2 + gnt wait + rvalid wait.
// Backpressure: ready_o only in IDLE; optional MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module memory_access
  import mem_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2_data_i,
  input  logic [2:0]        funct3_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic              regwren_i,
  input  logic [4:0]        rd_i,
  input  logic              brtaken_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] alu_res_o,
  output logic [DWIDTH-1:0] memory_data_o,
  output logic              brtaken_o,
  output logic              regwren_o,
  output logic [4:0]        rd_o,
  output logic              misalign_o
);

  mem_state_e state_q, state_d;

  logic [AWIDTH-1:0]   pc_q;
  logic [DWIDTH-1:0]   alu_q, rs2_q;
  logic [2:0]          f3_q;
  logic                store_q, regwren_q, brtaken_q;
  logic [4:0]          rd_q;
  logic                in_mem, in_trap;
  logic                accept, direct, complete_mem, load_done;
  logic [1:0]          a_lo;
  logic [BE_WIDTH-1:0] be_raw;
  logic [DWIDTH-1:0]   wdata_raw, ext_data;

  assign in_mem = memren_i | memwren_i;
`ifdef MEM_MISALIGN_TRAP_EN
  assign in_trap = in_mem & is_misaligned(alu_res_i[1:0], funct3_i);
`else
  assign in_trap = 1'b0;
`endif

  // Low address bits after forced alignment; a trapped access never reaches REQ.
  assign a_lo    = align_lo(alu_q[1:0], f3_q);
  assign ready_o = (state_q == IDLE) && !reset;

  load_extend u_load_extend (
    .rdata    (dmem_rdata_i),
    .a        (a_lo),
    .funct3   (f3_q),
    .ext_data (ext_data)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and handshake decode; rvalid is only honoured once gnt has been seen
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    direct       = 1'b0;
    complete_mem = 1'b0;
    load_done    = 1'b0;
    dmem_req_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          accept = 1'b1;
          if (in_mem && !in_trap) state_d = REQ;
          else                    direct  = 1'b1;
        end
      end
      REQ: begin
        dmem_req_o = 1'b1;
        if (dmem_gnt_i) begin
          if (store_q) begin
            complete_mem = 1'b1;
            state_d      = IDLE;
          end else if (dmem_rvalid_i) begin
            complete_mem = 1'b1;
            load_done    = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (dmem_rvalid_i) begin
          complete_mem = 1'b1;
          load_done    = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // byte enables and lane-replicated store data from the latched access
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be_raw    = 4'b0001 << a_lo;
        wdata_raw = {4{rs2_q[7:0]}};
      end
      2'b01: begin
        be_raw    = 4'b0011 << a_lo;
        wdata_raw = {2{rs2_q[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_raw = rs2_q;
      end
    endcase
  end

  // port fields are only driven while a request is outstanding
  assign dmem_we_o    = dmem_req_o & store_q;
  assign dmem_addr_o  = dmem_req_o ? {alu_q[AWIDTH-1:2], 2'b00} : '0;
  assign dmem_be_o    = dmem_req_o ? be_raw : '0;
  assign dmem_wdata_o = dmem_req_o ? wdata_raw : '0;

  // capture the instruction from execute when it is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      alu_q     <= '0;
      rs2_q     <= '0;
      f3_q      <= '0;
      store_q   <= 1'b0;
      regwren_q <= 1'b0;
      brtaken_q <= 1'b0;
      rd_q      <= '0;
    end else if (accept) begin
      pc_q      <= pc_i;
      alu_q     <= alu_res_i;
      rs2_q     <= rs2_data_i;
      f3_q      <= funct3_i;
      store_q   <= memwren_i;
      regwren_q <= regwren_i;
      brtaken_q <= brtaken_i;
      rd_q      <= rd_i;
    end
  end

  // MEM/WB register: loads on completion, valid_o pulses for that one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o       <= 1'b0;
      pc_o          <= '0;
      alu_res_o     <= '0;
      memory_data_o <= '0;
      brtaken_o     <= 1'b0;
      regwren_o     <= 1'b0;
      rd_o          <= '0;
      misalign_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (direct) begin
        valid_o       <= 1'b1;
        pc_o          <= pc_i;
        alu_res_o     <= alu_res_i;
        memory_data_o <= '0;
        brtaken_o     <= brtaken_i;
        regwren_o     <= regwren_i & ~in_trap;
        rd_o          <= rd_i;
        misalign_o    <= in_trap;
      end else if (complete_mem) begin
        valid_o       <= 1'b1;
        pc_o          <= pc_q;
        alu_res_o     <= alu_q;
        memory_data_o <= load_done ? ext_data : '0;
        brtaken_o     <= brtaken_q;
        regwren_o     <= regwren_q;
        rd_o          <= rd_q;
        misalign_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected MEM/WB records are queued at issue
// and popped when valid_o pulses; dmem port fields are checked while requesting.
// Honours MEM_MISALIGN_TRAP_EN for the misaligned-word case.
module tb_memory_access;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, ready_o;
  logic [31:0] pc_i, alu_res_i, rs2_data_i;
  logic [2:0]  funct3_i;
  logic        memren_i, memwren_i, regwren_i, brtaken_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [31:0] pc_o, alu_res_o, memory_data_o;
  logic        brtaken_o, regwren_o, misalign_o;
  logic [4:0]  rd_o;

  memory_access dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .alu_res_i(alu_res_i), .rs2_data_i(rs2_data_i), .funct3_i(funct3_i),
    .memren_i(memren_i), .memwren_i(memwren_i), .regwren_i(regwren_i), .rd_i(rd_i),
    .brtaken_i(brtaken_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .pc_o(pc_o), .alu_res_o(alu_res_o), .memory_data_o(memory_data_o),
    .brtaken_o(brtaken_o), .regwren_o(regwren_o), .rd_o(rd_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc, alu, md;
    logic        br, rw, mis;
    logic [4:0]  rd;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard monitor: every valid_o pulse must match the oldest queued record
  always @(negedge clk) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_cycle", cyc, e.at);
        chk("wb_pc", pc_o, e.pc);
        chk("wb_alu", alu_res_o, e.alu);
        chk("wb_mdata", memory_data_o, e.md);
        chk("wb_br", brtaken_o, e.br);
        chk("wb_regwren", regwren_o, e.rw);
        chk("wb_rd", rd_o, e.rd);
        chk("wb_misalign", misalign_o, e.mis);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("ready_timeout", 0, 1);
  endtask

  task automatic drive(input logic [31:0] pc, alu, rs2, input logic [2:0] f3,
                       input logic ld, st, rw, br, input logic [4:0] rd);
    valid_i = 1'b1; pc_i = pc; alu_res_i = alu; rs2_data_i = rs2; funct3_i = f3;
    memren_i = ld; memwren_i = st; regwren_i = rw; brtaken_i = br; rd_i = rd;
  endtask

  task automatic alu_op(input logic [31:0] pc, alu, input logic [4:0] rd, input logic br);
    exp_t e;
    wait_ready();
    drive(pc, alu, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, br, rd);
    e = '{pc: pc, alu: alu, md: 32'h0, br: br, rw: 1'b1, mis: 1'b0, rd: rd, at: cyc + 1};
    sb.push_back(e);
    @(negedge clk);
    valid_i = 1'b0;
    chk("alu_no_req", dmem_req_o, 0);
    chk("alu_ready", ready_o, 1);
  endtask

  // gd: cycles with gnt low before gnt; rv: cycles from gnt to rvalid (0 = same cycle)
  task automatic mem_op(input logic [31:0] pc, addr, rs2, input logic [2:0] f3,
                        input logic ld, st, input int gd, rv, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, e_md);
    exp_t e;
    wait_ready();
    drive(pc, addr, rs2, f3, ld, st, ld & ~st, 1'b1, 5'd9);
    e = '{pc: pc, alu: addr, md: e_md, br: 1'b1, rw: ld & ~st, mis: 1'b0, rd: 5'd9,
          at: cyc + 2 + gd + (st ? 0 : rv)};
    sb.push_back(e);
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 0; i <= gd; i++) begin
      chk("req", dmem_req_o, 1);
      chk("ready_busy", ready_o, 0);
      chk("addr", dmem_addr_o, e_addr);
      chk("we", dmem_we_o, st);
      if (st) begin
        chk("be", dmem_be_o, e_be);
        chk("wdata", dmem_wdata_o, e_wdata);
      end
      if (i == gd) begin
        dmem_gnt_i = 1'b1;
        dmem_rvalid_i = !st && rv == 0;
        dmem_rdata_i = rdata;
      end else begin
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = (i == 0);
        dmem_rdata_i = 32'hDEAD_0000;
      end
      @(negedge clk);
    end
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    if (!st && rv > 0) begin
      repeat (rv - 1) @(negedge clk);
      chk("resp_no_req", dmem_req_o, 0);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i = rdata;
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    valid_i = 1'b0; pc_i = '0; alu_res_i = '0; rs2_data_i = '0; funct3_i = '0;
    memren_i = 1'b0; memwren_i = 1'b0; regwren_i = 1'b0; brtaken_i = 1'b0; rd_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_addr", dmem_addr_o, 0);
    chk("rst_be", dmem_be_o, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready_o, 1);

    // non-memory ops, the second issued back-to-back
    alu_op(32'h0000_1000, 32'h0000_0042, 5'd5, 1'b0);
    alu_op(32'h0000_1004, 32'h0000_0077, 5'd6, 1'b1);
    @(negedge clk);

    // stores: SB high lane, SH upper half, SW, funct3 100 as SB, memren+memwren as store
    mem_op(32'h100, 32'h0100_0003, 32'h0000_00AB, F3_LB, 0, 1, 0, 0, 0,
           32'h0100_0000, 4'b1000, 32'hABAB_ABAB, 32'h0);
    mem_op(32'h104, 32'h0000_3002, 32'h1234_CDEF, F3_LH, 0, 1, 1, 0, 0,
           32'h0000_3000, 4'b1100, 32'hCDEF_CDEF, 32'h0);
    mem_op(32'h108, 32'h0000_3000, 32'hDEAD_BEEF, F3_LW, 0, 1, 0, 0, 0,
           32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    mem_op(32'h10C, 32'h0000_3301, 32'h0000_0055, F3_LBU, 0, 1, 0, 0, 0,
           32'h0000_3300, 4'b0010, 32'h5555_5555, 32'h0);
    mem_op(32'h110, 32'h0000_3104, 32'hCAFE_F00D, F3_LW, 1, 1, 0, 0, 0,
           32'h0000_3104, 4'b1111, 32'hCAFE_F00D, 32'h0);

    // loads: LB/LBU with rvalid a cycle after gnt, LH with gnt wait and same-cycle rvalid
    mem_op(32'h200, 32'h0000_2002, 32'h0, F3_LB, 1, 0, 0, 1, 32'h0080_0000,
           32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_FF80);
    mem_op(32'h204, 32'h0000_2002, 32'h0, F3_LBU, 1, 0, 0, 1, 32'h0080_0000,
           32'h0000_2000, 4'b0000, 32'h0, 32'h0000_0080);
    mem_op(32'h208, 32'h0000_2102, 32'h0, F3_LH, 1, 0, 3, 0, 32'h8001_0000,
           32'h0000_2100, 4'b0000, 32'h0, 32'hFFFF_8001);
    mem_op(32'h20C, 32'h0000_2200, 32'h0, F3_LHU, 1, 0, 0, 0, 32'h1234_F00D,
           32'h0000_2200, 4'b0000, 32'h0, 32'h0000_F00D);
    mem_op(32'h210, 32'h0000_2300, 32'h0, 3'b011, 1, 0, 1, 2, 32'hA5A5_0001,
           32'h0000_2300, 4'b0000, 32'h0, 32'hA5A5_0001);

    // misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    begin
      exp_t e;
      wait_ready();
      drive(32'h300, 32'h0000_4001, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3);
      e = '{pc: 32'h300, alu: 32'h0000_4001, md: 32'h0, br: 1'b0, rw: 1'b0, mis: 1'b1,
            rd: 5'd3, at: cyc + 1};
      sb.push_back(e);
      @(negedge clk);
      valid_i = 1'b0;
      chk("trap_no_req", dmem_req_o, 0);
      chk("trap_ready", ready_o, 1);
      @(negedge clk);
    end
`else
    mem_op(32'h300, 32'h0000_4001, 32'h0, F3_LW, 1, 0, 0, 1, 32'h1122_3344,
           32'h0000_4000, 4'b0000, 32'h0, 32'h1122_3344);
`endif
    @(negedge clk);

    // reset while waiting in RESP, then a late rvalid/gnt after release
    wait_ready();
    drive(32'h400, 32'h0000_5000, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12);
    @(negedge clk);
    valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    chk("resp_req_low", dmem_req_o, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", ready_o, 0);
    chk("mid_rst_req", dmem_req_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_pc", pc_o, 0);
    chk("mid_rst_alu", alu_res_o, 0);
    chk("mid_rst_mdata", memory_data_o, 0);
    chk("mid_rst_rd", rd_o, 0);
    chk("mid_rst_br", brtaken_o, 0);
    @(negedge clk);
    reset = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_gnt_i = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    dmem_gnt_i = 1'b0;
    chk("late_rvalid_no_valid", valid_o, 0);
    chk("late_rvalid_ready", ready_o, 1);
    chk("late_rvalid_no_req", dmem_req_o, 0);
    chk("late_rvalid_mdata", memory_data_o, 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
